// File: rtl/pipeline_hazard_controller_if.sv
// ID-stage hazard inputs and pipeline control outputs
// for the hazard controller.
interface pipeline_hazard_controller_if #(
  parameter int STALL_CNT_W = 16
);

  logic                   id_valid;
  logic                   id_annul;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic [4:0]             id_rd;
  logic                   id_use_rs1;
  logic                   id_use_rs2;
  logic                   id_use_rd;
  logic                   id_rf_enable;
  logic                   id_load;

  logic                   pc_le;
  logic                   ifid_le;
  logic                   cu_mux_s;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic [1:0]             fwd_c;
  logic                   stall_active;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid,
    output id_annul,
    output id_rs1,
    output id_rs2,
    output id_rd,
    output id_use_rs1,
    output id_use_rs2,
    output id_use_rd,
    output id_rf_enable,
    output id_load,
    input  pc_le,
    input  ifid_le,
    input  cu_mux_s,
    input  fwd_a,
    input  fwd_b,
    input  fwd_c,
    input  stall_active,
    input  stall_count
  );

  modport slave (
    input  id_valid,
    input  id_annul,
    input  id_rs1,
    input  id_rs2,
    input  id_rd,
    input  id_use_rs1,
    input  id_use_rs2,
    input  id_use_rd,
    input  id_rf_enable,
    input  id_load,
    output pc_le,
    output ifid_le,
    output cu_mux_s,
    output fwd_a,
    output fwd_b,
    output fwd_c,
    output stall_active,
    output stall_count
  );

endinterface

// File: rtl/pipeline_hazard_controller.sv
// RAW hazard detection, stall sequencing and operand
// forwarding selects for the 5-stage SPARC pipeline.
module pipeline_hazard_controller #(
  parameter bit FORWARDING  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input logic clk,
  input logic clr,
  pipeline_hazard_controller_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_en;
    logic       load;
  } shadow_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  shadow_t ex_q;
  shadow_t mem_q;
  shadow_t wb_q;

  state_t state;
  state_t state_nx;

  logic                   armed;
  logic                   live;
  logic                   annul;
  logic                   stall;
  logic                   active;
  logic [STALL_CNT_W-1:0] count;

  // {wb, mem, ex} match vectors per source field
  logic [2:0] m_a;
  logic [2:0] m_b;
  logic [2:0] m_c;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] sel_c;

  // r0 is hardwired zero, so it never creates a dependency
  function automatic logic hit(
    input shadow_t    e,
    input logic [4:0] x,
    input logic       use_x
  );
    return e.valid & e.rf_en & (e.rd == x)
         & (x != 5'd0) & use_x;
  endfunction

  // EX beats MEM beats WB; a load still in EX reads RF
  // because the stall will hold ID until it reaches MEM
  function automatic logic [1:0] pick(
    input logic [2:0] m,
    input logic       ex_load
  );
    logic [2:0] first;
    logic [1:0] r;
    first = m & (~m + 3'd1);
    r     = 2'b00;
    unique case (1'b1)
      first[0]: r = ex_load ? 2'b00 : 2'b01;
      first[1]: r = 2'b10;
      first[2]: r = 2'b11;
      default:  r = 2'b00;
    endcase
    return r;
  endfunction

  // inputs count only from the first edge after reset
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  assign live  = armed & bus.id_valid & ~bus.id_annul;
  assign annul = armed & bus.id_annul;

  // compare ID sources against every in-flight producer
  always_comb begin
    m_a = 3'b000;
    m_b = 3'b000;
    m_c = 3'b000;
    if (live) begin
      m_a = {hit(wb_q,  bus.id_rs1, bus.id_use_rs1),
             hit(mem_q, bus.id_rs1, bus.id_use_rs1),
             hit(ex_q,  bus.id_rs1, bus.id_use_rs1)};
      m_b = {hit(wb_q,  bus.id_rs2, bus.id_use_rs2),
             hit(mem_q, bus.id_rs2, bus.id_use_rs2),
             hit(ex_q,  bus.id_rs2, bus.id_use_rs2)};
      m_c = {hit(wb_q,  bus.id_rd,  bus.id_use_rd),
             hit(mem_q, bus.id_rd,  bus.id_use_rd),
             hit(ex_q,  bus.id_rd,  bus.id_use_rd)};
    end
  end

  // without forwarding any producer in flight blocks ID
  always_comb begin
    stall = 1'b0;
    if (FORWARDING) begin
      stall = ex_q.load & (m_a[0] | m_b[0] | m_c[0]);
    end else begin
      stall = |{m_a, m_b, m_c};
    end
  end

  // operand mux selects for the ID-stage operand muxes
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    sel_c = 2'b00;
    if (FORWARDING) begin
      sel_a = pick(m_a, ex_q.load);
      sel_b = pick(m_b, ex_q.load);
      sel_c = pick(m_c, ex_q.load);
    end
  end

  // shadow of EX/MEM/WB destinations; stalls insert bubbles
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (stall || !live) begin
        ex_q <= '0;
      end else begin
        ex_q.valid <= 1'b1;
        ex_q.rd    <= bus.id_rd;
        ex_q.rf_en <= bus.id_rf_enable;
        ex_q.load  <= bus.id_load;
      end
    end
  end

  // stall FSM state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // stall FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     state_nx = stall ? STALL : RUN;
      STALL:   state_nx = stall ? STALL : RUN;
      default: state_nx = RUN;
    endcase
  end

  // stall FSM output
  always_comb begin
    active = 1'b0;
    unique case (state)
      RUN:     active = 1'b0;
      STALL:   active = 1'b1;
      default: active = 1'b0;
    endcase
  end

  // saturating count of stalled cycles
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (stall && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign bus.pc_le        = ~stall;
  assign bus.ifid_le      = ~stall;
  assign bus.cu_mux_s     = stall | annul;
  assign bus.fwd_a        = sel_a;
  assign bus.fwd_b        = sel_b;
  assign bus.fwd_c        = sel_c;
  assign bus.stall_active = active;
  assign bus.stall_count  = count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller:
// forwarding, non-forwarding and narrow-counter builds.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic       valid;
    logic       annul;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       ud;
    logic       rf;
    logic       ld;
  } stim_t;

  typedef struct {
    int          tag;
    logic [9:0]  v;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;

  stim_t s_fw  = '0;
  stim_t s_nf  = '0;
  stim_t s_sat = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t        sb[$];
  stim_t       pl_s[$];
  logic [9:0]  pl_v[$];
  logic [15:0] pl_c[$];

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.STALL_CNT_W(16)) if_fw ();
  pipeline_hazard_controller_if #(.STALL_CNT_W(16)) if_nf ();
  pipeline_hazard_controller_if #(.STALL_CNT_W(2))  if_sat ();

  pipeline_hazard_controller #(
    .FORWARDING(1'b1), .STALL_CNT_W(16)
  ) u_fw (.clk(clk), .clr(clr), .bus(if_fw));

  pipeline_hazard_controller #(
    .FORWARDING(1'b0), .STALL_CNT_W(16)
  ) u_nf (.clk(clk), .clr(clr), .bus(if_nf));

  pipeline_hazard_controller #(
    .FORWARDING(1'b1), .STALL_CNT_W(2)
  ) u_sat (.clk(clk), .clr(clr), .bus(if_sat));

  assign {if_fw.id_valid, if_fw.id_annul, if_fw.id_rs1,
          if_fw.id_rs2, if_fw.id_rd, if_fw.id_use_rs1,
          if_fw.id_use_rs2, if_fw.id_use_rd,
          if_fw.id_rf_enable, if_fw.id_load} = s_fw;
  assign {if_nf.id_valid, if_nf.id_annul, if_nf.id_rs1,
          if_nf.id_rs2, if_nf.id_rd, if_nf.id_use_rs1,
          if_nf.id_use_rs2, if_nf.id_use_rd,
          if_nf.id_rf_enable, if_nf.id_load} = s_nf;
  assign {if_sat.id_valid, if_sat.id_annul, if_sat.id_rs1,
          if_sat.id_rs2, if_sat.id_rd, if_sat.id_use_rs1,
          if_sat.id_use_rs2, if_sat.id_use_rd,
          if_sat.id_rf_enable, if_sat.id_load} = s_sat;

  logic [9:0]  o_fw;
  logic [9:0]  o_nf;
  logic [9:0]  o_sat;
  logic [15:0] c_fw;
  logic [15:0] c_nf;
  logic [15:0] c_sat;

  assign o_fw  = {if_fw.pc_le, if_fw.ifid_le, if_fw.cu_mux_s,
                  if_fw.fwd_a, if_fw.fwd_b, if_fw.fwd_c,
                  if_fw.stall_active};
  assign o_nf  = {if_nf.pc_le, if_nf.ifid_le, if_nf.cu_mux_s,
                  if_nf.fwd_a, if_nf.fwd_b, if_nf.fwd_c,
                  if_nf.stall_active};
  assign o_sat = {if_sat.pc_le, if_sat.ifid_le, if_sat.cu_mux_s,
                  if_sat.fwd_a, if_sat.fwd_b, if_sat.fwd_c,
                  if_sat.stall_active};
  assign c_fw  = if_fw.stall_count;
  assign c_nf  = if_nf.stall_count;
  assign c_sat = {14'd0, if_sat.stall_count};

  function automatic stim_t op(
    input int rs1, input int rs2, input int rd,
    input bit u1, input bit u2, input bit ud,
    input bit rf, input bit ld
  );
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.rs1   = 5'(rs1);
    s.rs2   = 5'(rs2);
    s.rd    = 5'(rd);
    s.u1    = u1;
    s.u2    = u2;
    s.ud    = ud;
    s.rf    = rf;
    s.ld    = ld;
    return s;
  endfunction

  function automatic stim_t ld5();
    return op(0, 0, 5, 0, 0, 0, 1, 1);
  endfunction

  function automatic stim_t add(
    input int a, input int b, input int d
  );
    return op(a, b, d, 1, 1, 0, 1, 0);
  endfunction

  // {pc_le, ifid_le, cu_mux_s, fwd_a, fwd_b, fwd_c, stall_active}
  function automatic logic [9:0] E(
    input bit pc, input bit cu,
    input int fa, input int fb, input int fc,
    input bit sa
  );
    return {pc, pc, cu, 2'(fa), 2'(fb), 2'(fc), sa};
  endfunction

  task automatic plan(
    input stim_t s, input logic [9:0] v, input int c
  );
    pl_s.push_back(s);
    pl_v.push_back(v);
    pl_c.push_back(16'(c));
  endtask

  task automatic do_reset();
    clr   = 1'b0;
    s_fw  = '0;
    s_nf  = '0;
    s_sat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t g;
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      e.tag = ph;
      case (ph)
        0: begin
          @(negedge clk);
          e.v = E(1, 0, 0, 0, 0, 0); e.cnt = 16'd0;
        end
        1: begin
          s_fw = ld5();
          @(posedge clk);
          #1;
          s_fw = add(5, 7, 6);
          @(negedge clk);
          e.v = E(0, 1, 0, 0, 0, 0); e.cnt = 16'd0;
        end
        2: begin
          @(posedge clk);
          @(negedge clk);
          e.v = E(1, 0, 2, 0, 0, 1); e.cnt = 16'd1;
        end
        3: begin
          clr = 1'b0;
          #1;
          e.v = E(1, 0, 0, 0, 0, 0); e.cnt = 16'd0;
        end
        4: begin
          @(posedge clk);
          #1;
          e.v = E(1, 0, 0, 0, 0, 0); e.cnt = 16'd0;
        end
        default: begin
          @(negedge clk);
          clr = 1'b1;
          @(posedge clk);
          #1;
          e.v = E(1, 0, 0, 0, 0, 0); e.cnt = 16'd0;
        end
      endcase
      sb.push_back(e);
      g = sb.pop_front();
      n_cmp++;
      if (o_fw !== g.v) begin
        n_fail++;
        $display("FAIL reset[%0d] outs=%b want=%b",
                 g.tag, o_fw, g.v);
      end
      n_cmp++;
      if (c_fw !== g.cnt) begin
        n_fail++;
        $display("FAIL reset_cnt[%0d] got=%0d want=%0d",
                 g.tag, c_fw, g.cnt);
      end
    end
    s_fw = '0;
  endtask

  task automatic test_fwd_distance();
    exp_t e;
    exp_t g;
    int   t;
    do_reset();
    plan(add(1, 2, 3),  E(1, 0, 0, 0, 0, 0), 0);
    plan(add(3, 0, 10), E(1, 0, 1, 0, 0, 0), 0);
    plan(add(3, 0, 11), E(1, 0, 2, 0, 0, 0), 0);
    plan(add(3, 0, 12), E(1, 0, 3, 0, 0, 0), 0);
    plan(add(1, 2, 0),  E(1, 0, 0, 0, 0, 0), 0);
    plan(add(0, 0, 13), E(1, 0, 0, 0, 0, 0), 0);
    plan(op(0, 0, 13, 0, 0, 1, 0, 0),
         E(1, 0, 0, 0, 1, 0), 0);
    t = 0;
    while (pl_s.size() != 0) begin
      s_fw  = pl_s.pop_front();
      e.tag = t++;
      e.v   = pl_v.pop_front();
      e.cnt = pl_c.pop_front();
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      n_cmp++;
      if (o_fw !== g.v) begin
        n_fail++;
        $display("FAIL fwd_dist[%0d] outs=%b want=%b",
                 g.tag, o_fw, g.v);
      end
      n_cmp++;
      if (c_fw !== g.cnt) begin
        n_fail++;
        $display("FAIL fwd_dist_cnt[%0d] got=%0d want=%0d",
                 g.tag, c_fw, g.cnt);
      end
      @(posedge clk);
      #1;
    end
    s_fw = '0;
  endtask

  task automatic test_ex_priority();
    exp_t e;
    exp_t g;
    int   t;
    do_reset();
    plan(op(0, 0, 4, 0, 0, 0, 1, 0),
         E(1, 0, 0, 0, 0, 0), 0);
    plan(op(0, 0, 4, 0, 0, 0, 1, 0),
         E(1, 0, 0, 0, 0, 0), 0);
    plan(op(0, 4, 20, 0, 1, 0, 1, 0),
         E(1, 0, 0, 1, 0, 0), 0);
    plan(op(0, 4, 21, 0, 1, 0, 1, 0),
         E(1, 0, 0, 2, 0, 0), 0);
    t = 0;
    while (pl_s.size() != 0) begin
      s_fw  = pl_s.pop_front();
      e.tag = t++;
      e.v   = pl_v.pop_front();
      e.cnt = pl_c.pop_front();
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      n_cmp++;
      if (o_fw !== g.v) begin
        n_fail++;
        $display("FAIL ex_prio[%0d] outs=%b want=%b",
                 g.tag, o_fw, g.v);
      end
      @(posedge clk);
      #1;
    end
    s_fw = '0;
  endtask

  task automatic test_load_use();
    exp_t e;
    exp_t g;
    int   t;
    do_reset();
    plan(ld5(),        E(1, 0, 0, 0, 0, 0), 0);
    plan(add(5, 7, 6), E(0, 1, 0, 0, 0, 0), 0);
    plan(add(5, 7, 6), E(1, 0, 2, 0, 0, 1), 1);
    plan('0,           E(1, 0, 0, 0, 0, 0), 1);
    t = 0;
    while (pl_s.size() != 0) begin
      s_fw  = pl_s.pop_front();
      e.tag = t++;
      e.v   = pl_v.pop_front();
      e.cnt = pl_c.pop_front();
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      n_cmp++;
      if (o_fw !== g.v) begin
        n_fail++;
        $display("FAIL load_use[%0d] outs=%b want=%b",
                 g.tag, o_fw, g.v);
      end
      n_cmp++;
      if (c_fw !== g.cnt) begin
        n_fail++;
        $display("FAIL load_use_cnt[%0d] got=%0d want=%0d",
                 g.tag, c_fw, g.cnt);
      end
      @(posedge clk);
      #1;
    end
    s_fw = '0;
  endtask

  task automatic test_no_forwarding();
    exp_t e;
    exp_t g;
    int   t;
    do_reset();
    plan(op(0, 0, 9, 0, 0, 0, 1, 0),
         E(1, 0, 0, 0, 0, 0), 0);
    plan(add(9, 0, 14), E(0, 1, 0, 0, 0, 0), 0);
    plan(add(9, 0, 14), E(0, 1, 0, 0, 0, 1), 1);
    plan(add(9, 0, 14), E(0, 1, 0, 0, 0, 1), 2);
    plan(add(9, 0, 14), E(1, 0, 0, 0, 0, 1), 3);
    plan('0,            E(1, 0, 0, 0, 0, 0), 3);
    t = 0;
    while (pl_s.size() != 0) begin
      s_nf  = pl_s.pop_front();
      e.tag = t++;
      e.v   = pl_v.pop_front();
      e.cnt = pl_c.pop_front();
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      n_cmp++;
      if (o_nf !== g.v) begin
        n_fail++;
        $display("FAIL no_fwd[%0d] outs=%b want=%b",
                 g.tag, o_nf, g.v);
      end
      n_cmp++;
      if (c_nf !== g.cnt) begin
        n_fail++;
        $display("FAIL no_fwd_cnt[%0d] got=%0d want=%0d",
                 g.tag, c_nf, g.cnt);
      end
      @(posedge clk);
      #1;
    end
    s_nf = '0;
  endtask

  task automatic test_annul();
    exp_t  e;
    exp_t  g;
    stim_t a;
    int    t;
    do_reset();
    a       = add(5, 7, 6);
    a.annul = 1'b1;
    plan(ld5(),        E(1, 0, 0, 0, 0, 0), 0);
    plan(a,            E(1, 1, 0, 0, 0, 0), 0);
    plan(add(6, 0, 8), E(1, 0, 0, 0, 0, 0), 0);
    t = 0;
    while (pl_s.size() != 0) begin
      s_fw  = pl_s.pop_front();
      e.tag = t++;
      e.v   = pl_v.pop_front();
      e.cnt = pl_c.pop_front();
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      n_cmp++;
      if (o_fw !== g.v) begin
        n_fail++;
        $display("FAIL annul[%0d] outs=%b want=%b",
                 g.tag, o_fw, g.v);
      end
      n_cmp++;
      if (c_fw !== g.cnt) begin
        n_fail++;
        $display("FAIL annul_cnt[%0d] got=%0d want=%0d",
                 g.tag, c_fw, g.cnt);
      end
      @(posedge clk);
      #1;
    end
    s_fw = '0;
  endtask

  task automatic test_saturation();
    exp_t e;
    exp_t g;
    int   t;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      plan(ld5(), E(1, 0, 0, 0, 0, 0),
           (i < 3) ? i : 3);
      plan(add(5, 7, 6), E(0, 1, 0, 0, 0, 0),
           (i < 3) ? i : 3);
      plan(add(5, 7, 6), E(1, 0, 2, 0, 0, 1),
           (i + 1 < 3) ? i + 1 : 3);
    end
    plan('0, E(1, 0, 0, 0, 0, 0), 3);
    t = 0;
    while (pl_s.size() != 0) begin
      s_sat = pl_s.pop_front();
      e.tag = t++;
      e.v   = pl_v.pop_front();
      e.cnt = pl_c.pop_front();
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      n_cmp++;
      if (o_sat !== g.v) begin
        n_fail++;
        $display("FAIL sat[%0d] outs=%b want=%b",
                 g.tag, o_sat, g.v);
      end
      n_cmp++;
      if (c_sat !== g.cnt) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d] got=%0d want=%0d",
                 g.tag, c_sat, g.cnt);
      end
      @(posedge clk);
      #1;
    end
    s_sat = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_fwd_distance();
    test_ex_priority();
    test_no_forwarding();
    test_annul();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage SPARC pipeline: PC/nPC registers, IF/ID register, CU mux, ID/EX, EX/MEM and MEM/WB.
- Keeps a shadow scoreboard of in-flight destination registers for EX, MEM and WB.
- Detects RAW hazards against the instruction in ID and drives:
  - the load enables for PC/nPC/IF_ID;
  - the CU mux select S, which injects a NOP;
  - the operand forwarding selects for the ID-stage operand muxes.
- Sits beside the control unit and takes its inputs from the IF_ID outputs and the CU signals.

Parameters:
- FORWARDING, 1, 1 = forwarding paths exist, so only load-use stalls; 0 = stall until the producer has left WB.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  asynchronous, active-low reset (clr=0 resets).
- id_valid  in  1  ID holds a real instruction.
- id_annul  in  1  squash the ID instruction (annulled delay slot); it is treated as a NOP.
- id_rs1, id_rs2, id_rd  in  5 each  register fields from IF_ID.
- id_use_rs1, id_use_rs2, id_use_rd  in  1 each  the field is a source; id_use_rd is set for stores.
- id_rf_enable  in  1  the ID instruction writes rd.
- id_load  in  1  the ID instruction is a load.
- pc_le  out  1  LE for PC_Reg and nPC_Reg.
- ifid_le  out  1  LE for pipeline_IF_ID.
- cu_mux_s  out  1  S for control_unit_mux; 1 selects NOP.
- fwd_a, fwd_b, fwd_c  out  2 each  operand selects for rs1, rs2 and rd-as-source: 00 RF, 01 EX, 10 MEM, 11 WB.
- stall_active  out  1  the FSM is in STALL.
- stall_count  out  STALL_CNT_W  total stall cycles since reset, saturating.

Behaviour:
- Shadow entries EX, MEM and WB each hold {valid, rd, rf_en, load}.
- Shadow update on each rising clk:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (valid=0) if stall or id_annul or !id_valid; otherwise EX <= {1, id_rd, id_rf_enable, id_load}.
- Producer match for source x:
  - Requires entry.valid & entry.rf_en & entry.rd==x & x!=0 & use_x & id_valid & !id_annul.
  - r0 never hazards.
- Stall condition:
  - FORWARDING=1: any used source matches EX and EX.load=1 (load-use), giving exactly 1 bubble.
  - FORWARDING=0: any used source matches EX, MEM or WB; the stall is up to 3 cycles and resolves as bubbles advance.
- Outputs are combinational from the current ID inputs and the shadow state, so they are valid in the same cycle:
  - pc_le = ifid_le = !stall.
  - cu_mux_s = stall | id_annul.
- Forward select, FORWARDING=1:
  - Priority is EX (non-load) > MEM > WB; no match gives 00.
  - A matching EX load gives 00, because the stall covers it.
- Forward select, FORWARDING=0: always 00.
- FSM states and transitions:
  - RUN -> STALL when the stall condition is true at the clock edge.
  - STALL -> RUN when it is false; otherwise STALL is held.
  - stall_active = (state==STALL).
- stall_count increments on every edge where stall=1 and saturates at all-ones.
- Simultaneous id_annul and hazard: annul wins. No stall, cu_mux_s=1, EX receives a bubble.
- Reset (clr=0, at any time including mid-stall):
  - Shadow valids=0, state=RUN, stall_count=0.
  - Outputs immediately become pc_le=1, ifid_le=1, cu_mux_s=0, fwd_*=00, stall_active=0.
  - Held while clr=0. Inputs are ignored until the first rising edge after clr returns to 1.

Test Plan:
- Reset: clr=0 mid-stall -> outputs immediately pc_le=1, cu_mux_s=0, fwd_*=00, stall_count=0; after release, stall_active=0.
- FORWARDING=1: "ld r5" then "add r6,r5,r7" in ID -> 1 cycle with pc_le=0, ifid_le=0, cu_mux_s=1, stall_count=1; next cycle fwd_a=10 (MEM), pc_le=1.
- FORWARDING=1: add r3 writes, followed by uses of r3 at distances 1/2/3 -> fwd_a=01/10/11 respectively, no stall; a use of r0 -> fwd_a=00.
- FORWARDING=1: EX and MEM both write r4, ID reads r4 -> fwd_b=01 (EX priority).
- FORWARDING=0: producer of r9 then consumer of r9 -> 3 stall cycles, stall_active=1 for 3 cycles, then RUN with fwd_*=00; stall_count=3.
- id_annul=1 with a load-use match present -> no stall, cu_mux_s=1, the EX shadow becomes a bubble, so the next instruction reading that rd sees no EX match.
- Saturation with STALL_CNT_W=2: 5 load-use stalls -> stall_count=3.
